// File: rtl/aidan_mcnay_prime_host.sv
// Host-side initiator for the prime detector: shifts a candidate out on SDI/SCLK/CS,
// pulses ready, then returns the synchronized is_prime. Optional timeout: PRIME_HOST_TIMEOUT_EN.
module aidan_mcnay_prime_host #(
    parameter int unsigned nbits          = 31,
    parameter int unsigned CLK_DIV        = 8,
    parameter int unsigned READY_HOLD     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_num,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_is_prime,
    output logic             resp_timeout,
    output logic             SDI,
    output logic             SCLK,
    output logic             CS,
    output logic             ready,
    input  logic             done_in,
    input  logic             is_prime_in
);

    localparam int unsigned BIT_W  = $clog2(nbits + 1);
    localparam int unsigned PH_MAX = (CLK_DIV > READY_HOLD) ? CLK_DIV : READY_HOLD;
    localparam int unsigned PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_READY,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [nbits-1:0]   shift_q, shift_d;
    logic               done_s1_q, done_s2_q, done_sync_q;
    logic               prime_s1_q, prime_s2_q;
    logic               req_rdy_q, req_rdy_d;
    logic               resp_val_q, resp_val_d;
    logic               resp_is_prime_q, resp_is_prime_d;
    logic               sdi_q, sdi_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               ready_q, ready_d;
    logic               done_rise;

`ifdef PRIME_HOST_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               resp_timeout_q, resp_timeout_d;
`else
    // The timeout depth only matters when the timeout logic is built in.
    logic               unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    assign done_rise = done_s2_q & ~done_sync_q;

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        resp_is_prime_d = resp_is_prime_q;
`ifdef PRIME_HOST_TIMEOUT_EN
        to_cnt_d        = '0;
        resp_timeout_d  = resp_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    shift_d   = req_num;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                    state_d   = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    phase_d = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    phase_d   = '0;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    state_d   = (bit_cnt_q == BIT_W'(nbits - 1)) ? ST_READY : ST_SHIFT_LO;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_READY: begin
                if (phase_q == PH_W'(READY_HOLD - 1)) begin
                    phase_d = '0;
                    state_d = ST_WAIT_DONE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                // A done edge beats a simultaneous timeout expiry.
                if (done_rise) begin
                    resp_is_prime_d = prime_s2_q;
`ifdef PRIME_HOST_TIMEOUT_EN
                    resp_timeout_d  = 1'b0;
`endif
                    state_d         = ST_RESP;
                end
`ifdef PRIME_HOST_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_is_prime_d = 1'b0;
                    resp_timeout_d  = 1'b1;
                    state_d         = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin outputs follow the next state so they register in the same cycle as the state.
        req_rdy_d  = (state_d == ST_IDLE);
        resp_val_d = (state_d == ST_RESP);
        cs_d       = !((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI));
        sclk_d     = (state_d == ST_SHIFT_HI);
        ready_d    = (state_d == ST_READY);
        sdi_d      = 1'b0;
        if (state_d == ST_SHIFT_LO) begin
            sdi_d = shift_d[nbits-1];
        end else if (state_d == ST_SHIFT_HI) begin
            sdi_d = sdi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            phase_q         <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            done_s1_q       <= 1'b0;
            done_s2_q       <= 1'b0;
            done_sync_q     <= 1'b0;
            prime_s1_q      <= 1'b0;
            prime_s2_q      <= 1'b0;
            req_rdy_q       <= 1'b1;
            resp_val_q      <= 1'b0;
            resp_is_prime_q <= 1'b0;
            sdi_q           <= 1'b0;
            sclk_q          <= 1'b0;
            cs_q            <= 1'b1;
            ready_q         <= 1'b0;
`ifdef PRIME_HOST_TIMEOUT_EN
            to_cnt_q        <= '0;
            resp_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            done_s1_q       <= done_in;
            done_s2_q       <= done_s1_q;
            done_sync_q     <= done_s2_q;
            prime_s1_q      <= is_prime_in;
            prime_s2_q      <= prime_s1_q;
            req_rdy_q       <= req_rdy_d;
            resp_val_q      <= resp_val_d;
            resp_is_prime_q <= resp_is_prime_d;
            sdi_q           <= sdi_d;
            sclk_q          <= sclk_d;
            cs_q            <= cs_d;
            ready_q         <= ready_d;
`ifdef PRIME_HOST_TIMEOUT_EN
            to_cnt_q        <= to_cnt_d;
            resp_timeout_q  <= resp_timeout_d;
`endif
        end
    end

    assign req_rdy       = req_rdy_q;
    assign resp_val      = resp_val_q;
    assign resp_is_prime = resp_is_prime_q;
    assign SDI           = sdi_q;
    assign SCLK          = sclk_q;
    assign CS            = cs_q;
    assign ready         = ready_q;
`ifdef PRIME_HOST_TIMEOUT_EN
    assign resp_timeout  = resp_timeout_q;
`else
    assign resp_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_aidan_mcnay_prime_host.sv
// Directed bench for aidan_mcnay_prime_host (nbits=31, CLK_DIV=2, READY_HOLD=4, TIMEOUT_CYCLES=100).
module tb_aidan_mcnay_prime_host;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [30:0] req_num;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_is_prime;
    logic        resp_timeout;
    logic        SDI;
    logic        SCLK;
    logic        CS;
    logic        ready;
    logic        done_in;
    logic        is_prime_in;

    int n_cmp;
    int n_bad;
    int cyc;
    int hs_cyc;
    int rises;
    logic prev_sclk;

    aidan_mcnay_prime_host #(
        .nbits         (31),
        .CLK_DIV       (2),
        .READY_HOLD    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_num      (req_num),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_is_prime(resp_is_prime),
        .resp_timeout (resp_timeout),
        .SDI          (SDI),
        .SCLK         (SCLK),
        .CS           (CS),
        .ready        (ready),
        .done_in      (done_in),
        .is_prime_in  (is_prime_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycles elapsed since the request handshake edge (first post-handshake cycle is 1).
    task automatic run_to(input int target);
        while (cyc - hs_cyc < target) tick();
    endtask

    task automatic send(input logic [30:0] v);
        req_val = 1'b1;
        req_num = v;
        hs_cyc  = cyc;
        tick();
        req_val = 1'b0;
    endtask

    task automatic resp_handshake();
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        check("resp_val_drop", resp_val, 0);
        check("req_rdy_return", req_rdy, 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; hs_cyc = 0;
        reset = 1'b1; req_val = 1'b0; req_num = '0; resp_rdy = 1'b0;
        done_in = 1'b0; is_prime_in = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_req_rdy", req_rdy, 1);
        check("rst_resp_val", resp_val, 0);
        check("rst_is_prime", resp_is_prime, 0);
        check("rst_timeout", resp_timeout, 0);
        check("rst_sdi", SDI, 0);
        check("rst_sclk", SCLK, 0);
        check("rst_cs", CS, 1);
        check("rst_ready", ready, 0);
        reset = 1'b0;
        tick();
        check("idle_req_rdy", req_rdy, 1);

        // Frame shape for 0x7
        send(31'h7);
        check("cs_fall", CS, 0);
        check("sdi_first", SDI, 0);
        check("req_rdy_busy", req_rdy, 0);
        rises = 0;
        prev_sclk = 1'b0;
        while (cyc - hs_cyc < 130) begin
            if (SCLK && !prev_sclk) begin
                check("sclk_rise_cycle", cyc - hs_cyc, 3 + 4 * rises);
                check("sdi_bit", SDI, (rises >= 28) ? 1 : 0);
                rises++;
            end
            if (cyc - hs_cyc == 124) check("ready_pre", ready, 0);
            if (cyc - hs_cyc == 125) begin
                check("ready_rise", ready, 1);
                check("cs_rise", CS, 1);
                check("sclk_idle", SCLK, 0);
            end
            if (cyc - hs_cyc == 128) check("ready_hold", ready, 1);
            if (cyc - hs_cyc == 129) check("ready_fall", ready, 0);
            prev_sclk = SCLK;
            tick();
        end
        check("sclk_rise_count", rises, 31);

        // Result capture: done 40 cycles after ready
        run_to(165);
        done_in = 1'b1; is_prime_in = 1'b1;
        tick();
        check("cap_val_c1", resp_val, 0);
        tick();
        check("cap_val_c2", resp_val, 0);
        tick();
        check("cap_val_c3", resp_val, 1);
        check("cap_prime", resp_is_prime, 1);
        check("cap_timeout", resp_timeout, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_val", resp_val, 1);
            check("hold_prime", resp_is_prime, 1);
            check("hold_req_rdy", req_rdy, 0);
        end
        resp_handshake();

        // Stale done: done_in stays high from the previous transaction
        send(31'd11);
        run_to(150);
        check("stale_no_resp", resp_val, 0);
        done_in = 1'b0;
        run_to(155);
        check("stale_low_no_resp", resp_val, 0);
        done_in = 1'b1; is_prime_in = 1'b0;
        tick(); tick();
        check("stale_val_c2", resp_val, 0);
        tick();
        check("stale_val_c3", resp_val, 1);
        check("stale_prime", resp_is_prime, 0);
        resp_handshake();

        // Back-to-back: 9 -> 0, 13 -> 1
        done_in = 1'b0;
        send(31'd9);
        run_to(140);
        check("b2b1_wait", resp_val, 0);
        done_in = 1'b1; is_prime_in = 1'b0;
        tick(); tick(); tick();
        check("b2b1_val", resp_val, 1);
        check("b2b1_prime", resp_is_prime, 0);
        resp_rdy = 1'b1; req_val = 1'b1; req_num = 31'd13; done_in = 1'b0;
        tick();
        resp_rdy = 1'b0;
        check("b2b_resp_drop", resp_val, 0);
        check("b2b_req_rdy", req_rdy, 1);
        check("b2b_cs_still_high", CS, 1);
        hs_cyc = cyc;
        tick();
        req_val = 1'b0;
        check("b2b_cs_fall", CS, 0);
        check("b2b_sdi_msb", SDI, 0);
        run_to(140);
        done_in = 1'b1; is_prime_in = 1'b1;
        tick(); tick(); tick();
        check("b2b2_val", resp_val, 1);
        check("b2b2_prime", resp_is_prime, 1);
        resp_handshake();

        // Reset mid-shift
        done_in = 1'b0; is_prime_in = 1'b0;
        send(31'h5A5A5A5);
        run_to(30);
        check("mid_cs_low", CS, 0);
        reset = 1'b1;
        tick();
        check("mrst_cs", CS, 1);
        check("mrst_sclk", SCLK, 0);
        check("mrst_sdi", SDI, 0);
        check("mrst_ready", ready, 0);
        check("mrst_req_rdy", req_rdy, 1);
        check("mrst_resp_val", resp_val, 0);
        check("mrst_prime", resp_is_prime, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("post_rst_req_rdy", req_rdy, 1);
        check("post_rst_cs", CS, 1);

`ifdef PRIME_HOST_TIMEOUT_EN
        // Timeout with no done: WAIT_DONE entered at 129, expiry response at 229
        send(31'd17);
        run_to(228);
        check("to_not_yet", resp_val, 0);
        tick();
        check("to_val", resp_val, 1);
        check("to_flag", resp_timeout, 1);
        check("to_prime", resp_is_prime, 0);
        resp_handshake();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
